// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - request/grant, fill-control and RAM command bundle for sram_arbiter
//
// Members:
//   read  : rd_req, rd_addr (client) -> rd_gnt, rd_valid, rd_data (arbiter)
//   write : wr_req, wr_addr, wr_data (client) -> wr_gnt (arbiter)
//   fill  : clr_start, clr_color (client) -> clr_busy, clr_done (arbiter)
//   ram   : sram_we, sram_addr, sram_din (arbiter) -> sram_dout (RAM)
// Modports: master = clients plus RAM side, slave = the arbiter.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;

    logic                  clr_start;
    logic [DATA_WIDTH-1:0] clr_color;
    logic                  clr_busy;
    logic                  clr_done;

    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [DATA_WIDTH-1:0] sram_dout;

    modport master (
        output rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data,
        output wr_req, wr_addr, wr_data,
        input  wr_gnt,
        output clr_start, clr_color,
        input  clr_busy, clr_done,
        input  sram_we, sram_addr, sram_din,
        output sram_dout
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data,
        input  wr_req, wr_addr, wr_data,
        output wr_gnt,
        input  clr_start, clr_color,
        output clr_busy, clr_done,
        output sram_we, sram_addr, sram_din,
        input  sram_dout
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-port frame-buffer arbiter with write-starvation limit and frame fill
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - sram_arbiter_if.slave: read/write request channels, fill control, RAM command/return
//
// Read grants return rd_valid two cycles later (one cycle for the registered command,
// one for the synchronous RAM). A fill writes clr_color to every valid address, one per cycle.
module sram_arbiter #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 12,
    parameter int FRAME_WORDS   = 76800,
    parameter int WR_STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus
);
    localparam int                SW           = (WR_STARVE_MAX < 1) ? 1 : $clog2(WR_STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIMIT = SW'(WR_STARVE_MAX);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    // One extra bit so FRAME_WORDS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   FRAME_END = (ADDR_WIDTH + 1)'(FRAME_WORDS);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t                state;
    state_t                state_nxt;

    logic [SW-1:0]         starve_cnt;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_color_q;
    logic [1:0]            rd_pipe;
    logic                  clr_done_q;
    logic                  sram_we_q;
    logic [ADDR_WIDTH-1:0] sram_addr_q;
    logic [DATA_WIDTH-1:0] sram_din_q;

    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  clr_busy;
    logic                  clr_last;
    logic                  wr_in_range;

    assign clr_last    = (clr_addr == LAST_ADDR);
    assign wr_in_range = ({1'b0, bus.wr_addr} < FRAME_END);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (bus.clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)      state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Output logic. Grants are combinational from the requests, so they are also
    // gated by rst_n to keep every output low while reset is asserted.
    always_comb begin
        rd_gnt   = 1'b0;
        wr_gnt   = 1'b0;
        clr_busy = 1'b0;
        case (state)
            ARB: begin
                if (rst_n && !bus.clr_start) begin
                    if (bus.wr_req && (!bus.rd_req || starve_cnt == STARVE_LIMIT)) begin
                        wr_gnt = 1'b1;
                    end else begin
                        rd_gnt = bus.rd_req;
                    end
                end
            end
            CLEAR:   clr_busy = 1'b1;
            default: clr_busy = 1'b0;
        endcase
    end

    // Datapath: starvation counter, fill address, read-return pipeline, RAM command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt  <= '0;
            clr_addr    <= '0;
            clr_color_q <= '0;
            rd_pipe     <= '0;
            clr_done_q  <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[0], rd_gnt};
            clr_done_q <= (state == CLEAR) && clr_last;

            // Counts reads that overtook a waiting write; resets once the write
            // is served or withdrawn.
            if (wr_gnt || !bus.wr_req) begin
                starve_cnt <= '0;
            end else if (rd_gnt && starve_cnt != STARVE_LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == ARB) begin
                if (bus.clr_start) begin
                    clr_addr    <= '0;
                    clr_color_q <= bus.clr_color;
                end
            end else begin
                clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
            end

            if (state == CLEAR) begin
                sram_we_q   <= 1'b1;
                sram_addr_q <= clr_addr;
                sram_din_q  <= clr_color_q;
            end else if (wr_gnt) begin
                // Out-of-frame writes are accepted but never reach the RAM.
                sram_we_q   <= wr_in_range;
                sram_addr_q <= bus.wr_addr;
                sram_din_q  <= bus.wr_data;
            end else if (rd_gnt) begin
                sram_we_q   <= 1'b0;
                sram_addr_q <= bus.rd_addr;
            end else begin
                sram_we_q   <= 1'b0;
            end
        end
    end

    assign bus.rd_gnt    = rd_gnt;
    assign bus.wr_gnt    = wr_gnt;
    assign bus.clr_busy  = clr_busy;
    assign bus.clr_done  = clr_done_q;
    assign bus.rd_valid  = rd_pipe[1];
    assign bus.rd_data   = rd_pipe[1] ? bus.sram_dout : '0;
    assign bus.sram_we   = sram_we_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_din  = sram_din_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter against a frame-buffer model
module tb_sram_arbiter;
    localparam int AW   = 17;
    localparam int DW   = 12;
    localparam int FW   = 16;
    localparam int SMAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .FRAME_WORDS  (FW),
        .WR_STARVE_MAX(SMAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 16) return 12'hABC;
        return DW'(i * 37 + 5);
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.rd_gnt, bus.wr_gnt, bus.rd_valid, bus.rd_data, bus.clr_busy,
                    bus.clr_done, bus.sram_we, bus.sram_addr, bus.sram_din});
    endfunction

    // Synchronous single-port RAM: one command per edge, data out one edge later.
    logic [DW-1:0] ram [64];
    bit            ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            if (bus.sram_we) ram[bus.sram_addr[5:0]] <= bus.sram_din;
            bus.sram_dout <= ram[bus.sram_addr[5:0]];
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rd_ev_t;

    rd_ev_t        rq[$];
    logic [DW-1:0] shadow [64];
    bit            sh_loaded = 1'b0;
    int            cyc       = 0;
    bit            m_clear   = 1'b0;
    int            fill_idx  = 0;
    logic [DW-1:0] m_color   = '0;
    int            m_wait    = 0;
    bit            m_we      = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_din     = '0;
    bit            m_done    = 1'b0;

    always @(negedge clk) begin : model
        bit            e_rd;
        bit            e_wr;
        bit            e_valid;
        bit            was_clear;
        logic [DW-1:0] e_data;
        cyc++;
        if (!sh_loaded) begin
            for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
            sh_loaded = 1'b1;
        end
        if (!rst_n) begin
            chk("reset_all_zero", outs(), 64'd0);
            rq.delete();
            m_clear = 0; fill_idx = 0; m_wait = 0;
            m_we = 0; m_addr = '0; m_din = '0; m_done = 0;
        end else begin
            // The command visible now is taken by the RAM at the coming edge.
            if (m_we) shadow[m_addr[5:0]] = m_din;

            e_rd = 0;
            e_wr = 0;
            if (!m_clear && !bus.clr_start) begin
                if (bus.wr_req && (!bus.rd_req || m_wait == SMAX)) e_wr = 1;
                else if (bus.rd_req) e_rd = 1;
            end

            e_valid = 0;
            e_data  = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_valid = 1;
                e_data  = rq[0].data;
                void'(rq.pop_front());
            end

            chk("rd_gnt",    64'(bus.rd_gnt),    64'(e_rd));
            chk("wr_gnt",    64'(bus.wr_gnt),    64'(e_wr));
            chk("rd_valid",  64'(bus.rd_valid),  64'(e_valid));
            chk("rd_data",   64'(bus.rd_data),   64'(e_data));
            chk("clr_busy",  64'(bus.clr_busy),  64'(m_clear));
            chk("clr_done",  64'(bus.clr_done),  64'(m_done));
            chk("sram_we",   64'(bus.sram_we),   64'(m_we));
            chk("sram_addr", 64'(bus.sram_addr), 64'(m_addr));
            if (m_we) chk("sram_din", 64'(bus.sram_din), 64'(m_din));

            was_clear = m_clear;
            m_done    = 0;
            if (m_clear) begin
                m_we   = 1;
                m_addr = AW'(fill_idx);
                m_din  = m_color;
                fill_idx++;
                if (fill_idx == FW) begin
                    m_clear = 0;
                    m_done  = 1;
                end
            end else if (e_rd) begin
                m_we   = 0;
                m_addr = bus.rd_addr;
                rq.push_back('{cyc + 2, shadow[bus.rd_addr[5:0]]});
            end else if (e_wr) begin
                m_addr = bus.wr_addr;
                m_din  = bus.wr_data;
                m_we   = (int'(bus.wr_addr) < FW);
            end else begin
                m_we = 0;
            end

            if (!was_clear && bus.clr_start) begin
                m_clear  = 1;
                fill_idx = 0;
                m_color  = bus.clr_color;
            end

            if (e_wr || !bus.wr_req) m_wait = 0;
            else if (e_rd && m_wait < SMAX) m_wait++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int ncyc);
        bit rd_taken;
        bit wr_taken;
        rd_taken = 1;
        wr_taken = 1;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            if (!bus.rd_req || rd_taken) begin
                bus.rd_req  = ($urandom_range(0, 99) < 55);
                bus.rd_addr = AW'($urandom_range(0, 31));
            end
            if (!bus.wr_req || wr_taken) begin
                bus.wr_req  = ($urandom_range(0, 99) < 45);
                bus.wr_addr = AW'($urandom_range(0, 19));
                bus.wr_data = DW'($urandom);
            end
            bus.clr_start = ($urandom_range(0, 149) == 0);
            bus.clr_color = DW'($urandom);
            @(negedge clk);
            rd_taken = bus.rd_gnt;
            wr_taken = bus.wr_gnt;
        end
    endtask

    initial begin
        bit [9:0] pat_w;
        bit [9:0] pat_r;
        int       n_busy;
        int       n_we;
        int       n_done;
        int       n_g;
        bit       found;
        bit       drop;

        bus.rd_req = 0; bus.rd_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_start = 0; bus.clr_color = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", outs(), 64'd0);
        tick();
        rst_n = 1'b1;

        // Plain read of a preloaded word
        tick(); bus.rd_req = 1; bus.rd_addr = AW'('h10); #1;
        chk("rd_only_gnt", 64'(bus.rd_gnt), 64'd1);
        tick(); bus.rd_req = 0; #1;
        chk("rd_only_valid_early", 64'(bus.rd_valid), 64'd0);
        tick(); #1;
        chk("rd_only_valid", 64'(bus.rd_valid), 64'd1);
        chk("rd_only_data", 64'(bus.rd_data), 64'h ABC);
        tick(); #1;
        chk("rd_only_valid_width", 64'(bus.rd_valid), 64'd0);
        chk("rd_only_data_idle", 64'(bus.rd_data), 64'd0);

        // Write then read back
        tick(); bus.wr_req = 1; bus.wr_addr = AW'(5); bus.wr_data = 12'h123; #1;
        chk("wr_gnt_direct", 64'(bus.wr_gnt), 64'd1);
        tick(); bus.wr_req = 0; bus.rd_req = 1; bus.rd_addr = AW'(5); #1;
        chk("wr_cmd", 64'({bus.sram_we, bus.sram_addr, bus.sram_din}), 64'({1'b1, 17'd5, 12'h123}));
        chk("wr_then_rd_gnt", 64'(bus.rd_gnt), 64'd1);
        tick(); bus.rd_req = 0; #1;
        tick(); #1;
        chk("wr_then_rd_data", 64'({bus.rd_valid, bus.rd_data}), 64'({1'b1, 12'h123}));

        // Both requesting continuously: four reads then one write
        tick();
        bus.rd_req = 1; bus.rd_addr = AW'(1);
        bus.wr_req = 1; bus.wr_addr = AW'(2); bus.wr_data = 12'h456;
        for (int i = 0; i < 10; i++) begin
            #1;
            pat_w[i] = bus.wr_gnt;
            pat_r[i] = bus.rd_gnt;
            tick();
        end
        bus.rd_req = 0; bus.wr_req = 0;
        chk("starve_w_pattern", 64'(pat_w), 64'(10'b1000010000));
        chk("starve_r_pattern", 64'(pat_r), 64'(10'b0111101111));

        // Fill with a write waiting behind it
        tick();
        bus.clr_start = 1; bus.clr_color = 12'hF00;
        bus.wr_req = 1; bus.wr_addr = AW'(3); bus.wr_data = 12'h0AA; #1;
        chk("clr_start_blocks_gnt", 64'(bus.wr_gnt), 64'd0);
        n_busy = 0; n_we = 0; n_done = 0; n_g = 0; drop = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.clr_start = 0;
            if (drop) bus.wr_req = 0;
            #1;
            if (bus.clr_busy) begin
                n_busy++;
                if (bus.rd_gnt || bus.wr_gnt) n_g++;
            end
            if (bus.sram_we && bus.sram_din == 12'hF00 && bus.sram_addr == AW'(n_we)) n_we++;
            if (bus.clr_done) n_done++;
            if (bus.wr_gnt) drop = 1;
        end
        bus.wr_req = 0;
        chk("fill_busy_cycles", 64'(n_busy), 64'd16);
        chk("fill_writes", 64'(n_we), 64'd16);
        chk("fill_done_pulses", 64'(n_done), 64'd1);
        chk("fill_no_grants", 64'(n_g), 64'd0);
        chk("fill_wr_served_after", 64'(drop), 64'd1);

        // Out-of-frame write is consumed without touching the RAM
        tick(); bus.wr_req = 1; bus.wr_addr = AW'('h10); bus.wr_data = 12'h777; #1;
        chk("oor_gnt", 64'(bus.wr_gnt), 64'd1);
        tick(); bus.wr_req = 0; #1;
        chk("oor_we", 64'(bus.sram_we), 64'd0);

        // Reset in the middle of a fill
        tick(); bus.clr_start = 1; bus.clr_color = 12'h0F0; #1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            bus.clr_start = 0;
            #1;
            if (bus.sram_we && bus.sram_addr == AW'(7)) found = 1;
        end
        chk("fill_reaches_7", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midfill_reset_outputs", outs(), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.clr_done) n_done++;
            if (bus.clr_busy) n_busy++;
        end
        chk("no_done_after_reset", 64'(n_done), 64'd0);
        chk("no_busy_after_reset", 64'(n_busy), 64'd0);
        tick(); bus.clr_start = 1; bus.clr_color = 12'h0F0; #1;
        tick(); bus.clr_start = 0; #1;
        chk("restart_busy", 64'(bus.clr_busy), 64'd1);
        tick(); #1;
        chk("restart_first_addr", 64'({bus.sram_we, bus.sram_addr}), 64'({1'b1, 17'd0}));
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.clr_done) found = 1;
        end
        chk("restart_done", 64'(found), 64'd1);

        run_random(3000);

        tick();
        rst_n = 1'b1;
        bus.rd_req = 0; bus.wr_req = 0; bus.clr_start = 0;
        repeat (25) tick();
        chk("rd_queue_drained", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
